dwell_driver: RTL and testbench
===============================

// Module: dwell_driver
// PURPOSE
//  Output-side counterpart to input debouncing: drives a slow physical output
//  (relay, beeper, lamp) from a noisy or glitchy internal request. Guarantees
//  minimum on-time and minimum off-time dwell on o_out, and adds a one-shot
//  pulse request with a fixed length. Sits between CPU-facing control logic
//  and an FPGA output pin. o_out is registered and safe to drive directly.
// PARAMETERS
//  MIN_ON    default 10  minimum cycles o_out stays 1 once raised (>=1)
//  MIN_OFF   default 10  minimum cycles o_out stays 0 once lowered (>=1)
//  PULSE_LEN default 20  o_out high time for an i_pulse request (>=MIN_ON)
// PORTS
//  i_clk    in   1  clock, all logic on rising edge
//  i_rst_n  in   1  reset, asynchronous, active-low
//  i_level  in   1  level request: 1 = want output on
//  i_pulse  in   1  single-cycle strobe: request one PULSE_LEN pulse
//  o_out    out  1  driven output (registered)
//  o_busy   out  1  1 while a dwell interval is running (request ignored)
// BEHAVIOUR
//  - Reset (async, i_rst_n=0): state LOW, o_out=0, o_busy=0, counters 0, pulse
//    pending/active cleared. Applies immediately, including mid-dwell or
//    mid-pulse; after release the off-dwell is treated as already satisfied.
//  - target = i_level | pulse_active. Sampled every cycle, no synchroniser
//    (inputs are internal, same clock domain).
//  - States: LOW (o_out=0, dwell met), HIGH_DWELL (o_out=1, counting),
//    HIGH (o_out=1, dwell met), LOW_DWELL (o_out=0, counting).
//  - LOW: target=1 -> HIGH_DWELL, o_out=1 on the next edge (latency 1 cycle).
//  - HIGH_DWELL: count 0..MIN_ON-1, target ignored. On the last count:
//    target=0 -> LOW_DWELL, else -> HIGH. o_out high for >=MIN_ON cycles,
//    and exactly MIN_ON cycles for a 1-cycle glitch.
//  - HIGH: target=0 -> LOW_DWELL, o_out=0 on the next edge.
//  - LOW_DWELL: mirror of HIGH_DWELL using MIN_OFF. On the last count:
//    target=1 -> HIGH_DWELL, else -> LOW.
//  - o_busy = (state==HIGH_DWELL) | (state==LOW_DWELL). Registered with state.
//  - Counter width $clog2(max(MIN_ON,MIN_OFF,PULSE_LEN)+1). It resets to 0 on
//    every state entry and never wraps.
//  - Pulse handling:
//    - i_pulse sets pulse_pending.
//    - pulse_pending makes target=1. When o_out next rises, or immediately if
//      o_out is already 1, pending clears and pulse_active starts.
//    - pulse_active holds target=1 for PULSE_LEN cycles of o_out=1. With
//      i_level=0, o_out is high exactly PULSE_LEN cycles.
//    - i_pulse during pulse_active restarts the PULSE_LEN count (retrigger).
//    - i_pulse during LOW_DWELL stays pending until the dwell completes.
//  - i_level and i_pulse together: the high time is the longer of the two.
//    Neither request is lost.
//  - With MIN_ON=MIN_OFF=1 and no pulses, o_out = i_level delayed 1 cycle.
// TESTING  (MIN_ON=4, MIN_OFF=3, PULSE_LEN=6)
//  1. Hold i_rst_n=0 -> o_out=0, o_busy=0. Drop i_rst_n during HIGH_DWELL ->
//     o_out=0 at once (no clock edge). After release, i_level=1 -> o_out=1
//     one cycle later.
//  2. i_level 1-cycle glitch -> o_out=1 for exactly 4 cycles, then 0, o_busy
//     high for those 4 cycles plus 3 low cycles.
//  3. i_level high for 10 cycles -> o_out high 10 cycles, shifted by 1 cycle.
//  4. i_level low 1 cycle inside a long high (after dwell) -> o_out low
//     exactly 3 cycles, then high again.
//  5. i_pulse strobe, i_level=0 -> o_out high exactly 6 cycles. A second
//     strobe on cycle 4 of the pulse -> high 4+6=10 cycles in total.
//  6. i_pulse during LOW_DWELL (cycle 1 of 3) -> o_out rises when the dwell
//     ends and stays high 6 cycles. Pulse request is not dropped.

Source files
------------

// File: rtl/dwell_driver.sv
// dwell_driver: drives a slow physical output with guaranteed
// minimum on/off dwell and a retriggerable fixed-length pulse.
module dwell_driver #(
  parameter int MIN_ON    = 10,
  parameter int MIN_OFF   = 10,
  parameter int PULSE_LEN = 20
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_level,
  input  logic i_pulse,
  output logic o_out,
  output logic o_busy
);

  localparam int MX01 = (MIN_ON > MIN_OFF) ? MIN_ON : MIN_OFF;
  localparam int MAXV = (MX01 > PULSE_LEN) ? MX01 : PULSE_LEN;
  localparam int CW   = $clog2(MAXV + 1);

  localparam logic [CW-1:0] ON_LAST  = CW'(MIN_ON - 1);
  localparam logic [CW-1:0] OFF_LAST = CW'(MIN_OFF - 1);
  localparam logic [CW-1:0] PLS_LAST = CW'(PULSE_LEN - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);
  localparam logic          PLS_HOLD = (PULSE_LEN > 1);

  typedef enum logic [1:0] {
    S_LOW  = 2'd0,
    S_HDW  = 2'd1,
    S_HIGH = 2'd2,
    S_LDW  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] pcnt_q, pcnt_d;
  logic          pend_q, pend_d;
  logic          act_q, act_d;
  logic          out_q, out_d;
  logic          busy_q, busy_d;

  logic target;
  logic req;
  logic start;

  // next-state: dwell FSM plus pulse pending/active tracking
  always_comb begin
    target  = i_level | i_pulse | pend_q | act_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_LOW: begin
        if (target) begin
          state_d = S_HDW;
          cnt_d   = '0;
        end
      end
      S_HDW: begin
        if (cnt_q == ON_LAST) begin
          state_d = target ? S_HIGH : S_LDW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      S_HIGH: begin
        if (!target) begin
          state_d = S_LDW;
          cnt_d   = '0;
        end
      end
      S_LDW: begin
        if (cnt_q == OFF_LAST) begin
          state_d = target ? S_HDW : S_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
      default: begin
        state_d = S_LOW;
        cnt_d   = '0;
      end
    endcase

    out_d  = (state_d == S_HDW) | (state_d == S_HIGH);
    busy_d = (state_d == S_HDW) | (state_d == S_LDW);

    // a pulse request starts once the output is (or goes) high
    req    = i_pulse | pend_q;
    start  = req & out_d;
    pend_d = req & ~out_d;
    act_d  = act_q;
    pcnt_d = pcnt_q;
    if (start) begin
      act_d  = PLS_HOLD;
      pcnt_d = ONE;
    end else if (act_q) begin
      if (pcnt_q == PLS_LAST) begin
        act_d  = 1'b0;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + ONE;
      end
    end
  end

  // state and registered outputs
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_LOW;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      pend_q  <= 1'b0;
      act_q   <= 1'b0;
      out_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      pend_q  <= pend_d;
      act_q   <= act_d;
      out_q   <= out_d;
      busy_q  <= busy_d;
    end
  end

  assign o_out  = out_q;
  assign o_busy = busy_q;

endmodule

// File: tb/tb_dwell_driver.sv
// tb_dwell_driver: directed per-cycle vectors for dwell_driver
// with MIN_ON=4, MIN_OFF=3, PULSE_LEN=6.
module tb_dwell_driver;

  logic clk;
  logic rst_n;
  logic lvl;
  logic pls;
  logic out;
  logic busy;

  int errs;
  int checks;

  dwell_driver #(
    .MIN_ON   (4),
    .MIN_OFF  (3),
    .PULSE_LEN(6)
  ) dut (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_level(lvl),
    .i_pulse(pls),
    .o_out  (out),
    .o_busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic got,
                       input logic exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  // drive inputs for one cycle, then sample just after the edge
  task automatic step(input logic l, input logic p);
    lvl = l;
    pls = p;
    @(posedge clk);
    #1;
  endtask

  // per-cycle vectors: char i of each string is cycle i
  task automatic seq(input string tag,
                     input string sl,
                     input string sp,
                     input string so,
                     input string sb);
    for (int i = 0; i < sl.len(); i++) begin
      step(sl[i] == "1", sp[i] == "1");
      check($sformatf("%s_out%0d", tag, i), out, so[i] == "1");
      check($sformatf("%s_busy%0d", tag, i), busy, sb[i] == "1");
    end
    lvl = 1'b0;
    pls = 1'b0;
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    rst_n  = 1'b0;
    lvl    = 1'b0;
    pls    = 1'b0;

    // reset held, requests ignored
    step(1'b0, 1'b0);
    check("rst_out", out, 1'b0);
    check("rst_busy", busy, 1'b0);
    step(1'b1, 1'b1);
    check("rst_hold_out", out, 1'b0);
    check("rst_hold_busy", busy, 1'b0);
    lvl   = 1'b0;
    pls   = 1'b0;
    rst_n = 1'b1;

    // enter HIGH_DWELL, then async reset mid-dwell
    seq("t1a", "10", "00", "11", "11");
    #3 rst_n = 1'b0;
    #1;
    check("t1_async_out", out, 1'b0);
    check("t1_async_busy", busy, 1'b0);
    #1 rst_n = 1'b1;
    seq("t1c",
        "10000000",
        "00000000",
        "11110000",
        "11111110");

    // 1-cycle glitch
    seq("t2",
        "10000000",
        "00000000",
        "11110000",
        "11111110");

    // 10-cycle level
    seq("t3",
        "11111111110000",
        "00000000000000",
        "11111111110000",
        "11110000001110");

    // 1-cycle low inside a long high
    seq("t4",
        "1111111011111110000",
        "0000000000000000000",
        "1111111000111110000",
        "1111000111111101110");

    // single pulse
    seq("t5a",
        "0000000000",
        "1000000000",
        "1111110000",
        "1111001110");

    // retrigger on cycle 4 of the pulse
    seq("t5b",
        "00000000000000",
        "10001000000000",
        "11111111110000",
        "11110000001110");

    // pulse during LOW_DWELL is held pending
    seq("t6",
        "10000000000000000",
        "00000100000000000",
        "11110001111110000",
        "11111111111001110");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
